// File: rtl/rotary_step_decoder_if.sv
// Rotary encoder contacts in, detent event/direction/strobe/position out; master = decoder side.
// Combinational bundle only: no latency, no backpressure (outputs are levels and strobes).
interface rotary_step_decoder_if #(
  parameter int CNT_W = 8
) ();
  logic                    rot_a;
  logic                    rot_b;
  logic                    rotation_event;
  logic                    rotation_direction;
  logic                    step_pulse;
  logic signed [CNT_W-1:0] position;

  modport master (
    input  rot_a,
    input  rot_b,
    output rotation_event,
    output rotation_direction,
    output step_pulse,
    output position
  );

  modport slave (
    output rot_a,
    output rot_b,
    input  rotation_event,
    input  rotation_direction,
    input  step_pulse,
    input  position
  );
endinterface

// File: rtl/rotary_step_decoder.sv
// Rotary encoder front end: sync + debounce both contacts, one rotation_event rise per detent; ROT_POSITION_EN adds a wrapping signed count.
// rotation_event rises SYNC_STAGES+DEBOUNCE_CYCLES edges after a stable 11 is first sampled; no backpressure, outputs are levels/strobes.
module rotary_step_decoder #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 8
) (
  input logic                   clk,
  input logic                   reset,
  rotary_step_decoder_if.master bus
);
  localparam int            DW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {LOW, HIGH} state_t;

  logic [SYNC_STAGES-1:0] a_sync;
  logic [SYNC_STAGES-1:0] b_sync;
  logic                   a_s;
  logic                   b_s;
  logic                   a_f;
  logic                   b_f;
  logic [DW-1:0]          a_cnt;
  logic [DW-1:0]          b_cnt;
  logic [1:0]             ba;
  logic                   q1;
  logic                   q2;
  state_t                 state;
  logic                   rotation_event;
  logic                   rotation_direction;
  logic                   step_pulse;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_sync <= '0;
      b_sync <= '0;
    end else begin
      a_sync <= {a_sync[SYNC_STAGES-2:0], bus.rot_a};
      b_sync <= {b_sync[SYNC_STAGES-2:0], bus.rot_b};
    end
  end

  assign a_s = a_sync[SYNC_STAGES-1];
  assign b_s = b_sync[SYNC_STAGES-1];

  // A new level is taken on the edge where the run length would reach DEBOUNCE_CYCLES.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_f   <= 1'b0;
      a_cnt <= '0;
    end else if (a_s == a_f) begin
      a_cnt <= '0;
    end else if (a_cnt == DB_LAST) begin
      a_f   <= a_s;
      a_cnt <= '0;
    end else begin
      a_cnt <= a_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      b_f   <= 1'b0;
      b_cnt <= '0;
    end else if (b_s == b_f) begin
      b_cnt <= '0;
    end else if (b_cnt == DB_LAST) begin
      b_f   <= b_s;
      b_cnt <= '0;
    end else begin
      b_cnt <= b_cnt + 1'b1;
    end
  end

  assign ba = {b_f, a_f};

  // q2 remembers which contact moved first in the current quarter-cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q1 <= 1'b0;
      q2 <= 1'b0;
    end else begin
      case (ba)
        2'b00:   q1 <= 1'b0;
        2'b11:   q1 <= 1'b1;
        2'b01:   q2 <= 1'b0;
        default: q2 <= 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state              <= LOW;
      rotation_event     <= 1'b0;
      rotation_direction <= 1'b0;
      step_pulse         <= 1'b0;
    end else begin
      step_pulse <= 1'b0;
      case (state)
        LOW: if (ba == 2'b11) begin
          state              <= HIGH;
          rotation_event     <= 1'b1;
          rotation_direction <= q2;
          step_pulse         <= 1'b1;
        end
        HIGH: if (ba == 2'b00) begin
          state          <= LOW;
          rotation_event <= 1'b0;
        end
        default: state <= LOW;
      endcase
    end
  end

  // q1 tracks the same "both high" phase the FSM latches on.
  a_q1_tracks_state: assert property (@(posedge clk) disable iff (reset) q1 == (state == HIGH));

`ifdef ROT_POSITION_EN
  logic signed [CNT_W-1:0] pos_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pos_q <= '0;
    end else if (state == LOW && ba == 2'b11) begin
      pos_q <= q2 ? pos_q - 1'b1 : pos_q + 1'b1;
    end
  end

  assign bus.position = pos_q;
`else
  assign bus.position = '0;
`endif

  assign bus.rotation_event     = rotation_event;
  assign bus.rotation_direction = rotation_direction;
  assign bus.step_pulse         = step_pulse;
endmodule

// File: tb/tb_rotary_step_decoder.sv
// Directed bench for rotary_step_decoder: latency, direction, debounce, held input, reset, wrap.
module tb_rotary_step_decoder;
  localparam int SYNC_STAGES     = 2;
  localparam int DEBOUNCE_CYCLES = 4;
  localparam int CNT_W           = 8;
  // wait_evt counts edge k as 1, so a rise on edge k+SYNC+DEB reads back as this value
  localparam int EVT_LAT         = SYNC_STAGES + DEBOUNCE_CYCLES + 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rotary_step_decoder_if #(.CNT_W(CNT_W)) bus ();

  rotary_step_decoder #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int               errors   = 0;
  int               checks   = 0;
  int               step_cnt = 0;
  logic [CNT_W-1:0] pos_model = '0;

  always @(negedge clk) if (bus.step_pulse === 1'b1) step_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_pos(input string tag);
    logic [CNT_W-1:0] p;
    logic [CNT_W-1:0] e;
    p = bus.position;
`ifdef ROT_POSITION_EN
    e = pos_model;
`else
    e = '0;
`endif
    check(tag, 32'(p), 32'(e));
  endtask

  task automatic drive(input logic [1:0] ba_v, input int n);
    @(negedge clk);
    bus.rot_b = ba_v[1];
    bus.rot_a = ba_v[0];
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_evt(input logic v, output int lat);
    lat = 0;
    while (bus.rotation_event !== v && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic detent(input logic ccw);
    drive(ccw ? 2'b10 : 2'b01, 10);
    drive(2'b11, 10);
    drive(ccw ? 2'b01 : 2'b10, 10);
    drive(2'b00, 10);
    pos_model = ccw ? pos_model - 1'b1 : pos_model + 1'b1;
  endtask

  initial begin
    int lat;
    int s0;
    int lows;
    reset     = 1'b1;
    bus.rot_a = 1'b0;
    bus.rot_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_event", 32'(bus.rotation_event), 0);
    check("rst_dir", 32'(bus.rotation_direction), 0);
    check("rst_pulse", 32'(bus.step_pulse), 0);
    check_pos("rst_pos");
    @(negedge clk) reset = 1'b0;

    // clockwise: A leads
    drive(2'b01, 10);
    s0 = step_cnt;
    @(negedge clk);
    bus.rot_b = 1'b1;
    bus.rot_a = 1'b1;
    wait_evt(1'b1, lat);
    pos_model = pos_model + 1'b1;
    check("cw_latency", 32'(lat), 32'(EVT_LAT));
    check("cw_dir", 32'(bus.rotation_direction), 0);
    check("cw_pulse", 32'(bus.step_pulse), 1);
    check_pos("cw_pos");
    drive(2'b11, 10);
    check("cw_steps", 32'(step_cnt - s0), 1);
    drive(2'b10, 10);
    drive(2'b00, 10);
    check("cw_event_low", 32'(bus.rotation_event), 0);

    // counter-clockwise: B leads, then measure the fall
    drive(2'b10, 10);
    drive(2'b11, 10);
    pos_model = pos_model - 1'b1;
    check("ccw_event", 32'(bus.rotation_event), 1);
    check("ccw_dir", 32'(bus.rotation_direction), 1);
    check_pos("ccw_pos");
    drive(2'b01, 10);
    @(negedge clk);
    bus.rot_b = 1'b0;
    bus.rot_a = 1'b0;
    wait_evt(1'b0, lat);
    check("ccw_fall", 32'(lat), 32'(EVT_LAT));
    drive(2'b00, 10);

    // 3-clock glitch rejected, 4-clock hold accepted (direction from previous q2 = 0)
    s0 = step_cnt;
    drive(2'b11, DEBOUNCE_CYCLES - 1);
    drive(2'b00, 20);
    check("glitch_steps", 32'(step_cnt - s0), 0);
    check("glitch_event", 32'(bus.rotation_event), 0);
    drive(2'b11, DEBOUNCE_CYCLES);
    drive(2'b00, 20);
    pos_model = pos_model + 1'b1;
    check("hold4_steps", 32'(step_cnt - s0), 1);
    check("hold4_dir", 32'(bus.rotation_direction), 0);
    check_pos("hold4_pos");

    // held 11 for 200 clocks
    drive(2'b01, 10);
    s0 = step_cnt;
    @(negedge clk);
    bus.rot_b = 1'b1;
    bus.rot_a = 1'b1;
    wait_evt(1'b1, lat);
    pos_model = pos_model + 1'b1;
    lows = 0;
    repeat (200) begin
      @(posedge clk);
      #1;
      if (bus.rotation_event !== 1'b1) lows++;
    end
    check("held_event_drops", 32'(lows), 0);
    check("held_steps", 32'(step_cnt - s0), 1);
    drive(2'b10, 10);
    drive(2'b00, 10);

    // asynchronous reset while HIGH
    drive(2'b01, 10);
    drive(2'b11, 10);
    check("pre_rst_event", 32'(bus.rotation_event), 1);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_event", 32'(bus.rotation_event), 0);
    check("async_rst_dir", 32'(bus.rotation_direction), 0);
    check("async_rst_pulse", 32'(bus.step_pulse), 0);
    pos_model = '0;
    check_pos("async_rst_pos");
    bus.rot_b = 1'b0;
    bus.rot_a = 1'b0;
    @(negedge clk) reset = 1'b0;
    s0 = step_cnt;
    drive(2'b00, 20);
    check("post_rst_idle", 32'(step_cnt - s0), 0);
    detent(1'b0);
    check("post_rst_steps", 32'(step_cnt - s0), 1);
    check_pos("post_rst_pos");

    // wrap: 129 CW then 2 CCW from reset
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    pos_model = '0;
    s0 = step_cnt;
    for (int i = 0; i < 129; i++) detent(1'b0);
    check("wrap_steps", 32'(step_cnt - s0), 129);
    check_pos("wrap_pos_81");
    for (int i = 0; i < 2; i++) detent(1'b1);
    check_pos("wrap_pos_7f");
    check("wrap_dir", 32'(bus.rotation_direction), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
